nvme_fifo_arb: RTL and testbench

NVME_FIFO_ARB -- requirements
Module: nvme_fifo_arb

---
 rtl/nvme_fifo_arb.sv | 112 +++++++++++
 tb/tb_nvme_fifo_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/nvme_fifo_arb.sv
// Round-robin arbiter feeding a shared FIFO with per-grant burst locking
// and a fixed four-step flush sequence.
module nvme_fifo_arb #(
  parameter int width     = 8,
  parameter int nreq      = 4,
  parameter int max_burst = 4,
  parameter int iwidth    = $clog2(nreq)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [nreq-1:0]         req_valid,
  input  logic [nreq*width-1:0]   req_data,
  output logic [nreq-1:0]         req_ready,
  output logic                    fifo_push,
  output logic [width-1:0]        fifo_din,
  output logic                    fifo_flush,
  input  logic                    fifo_full,
  input  logic                    fifo_almost_full,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic [iwidth-1:0]       grant_id
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [iwidth-1:0] rr_ptr, lock_id, sel;
  logic              locked, sel_ok, blocked, push;
  logic [7:0]        burst_cnt;

  function automatic logic [iwidth-1:0] next_idx(input logic [iwidth-1:0] p);
    return (int'(p) == nreq - 1) ? '0 : p + iwidth'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush_req) state_nxt = DRAIN;
      DRAIN:   state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = flush_req ? DRAIN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    if (locked) begin
      sel    = lock_id;
      sel_ok = req_valid[lock_id];
    end else if (!fifo_almost_full) begin
      for (int k = nreq - 1; k >= 0; k--) begin
        automatic int idx = int'(rr_ptr) + k;
        if (idx >= nreq) idx = idx - nreq;
        if (req_valid[idx]) begin
          sel    = idx[iwidth-1:0];
          sel_ok = 1'b1;
        end
      end
    end
  end

  assign blocked    = reset || fifo_full || (state != IDLE) || flush_req;
  assign req_ready  = (sel_ok && !blocked) ? ({{(nreq-1){1'b0}}, 1'b1} << sel) : '0;
  assign push       = |(req_valid & req_ready);
  assign fifo_push  = push;
  assign fifo_din   = push ? req_data[int'(sel)*width +: width] : '0;
  assign fifo_flush = (state == FLUSH);
  assign flush_done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lock_id   <= '0;
      locked    <= 1'b0;
      burst_cnt <= '0;
      grant_id  <= '0;
    end else begin
      state <= state_nxt;
      if (push) grant_id <= sel;
      if (state == FLUSH) begin
        rr_ptr    <= '0;
        locked    <= 1'b0;
        burst_cnt <= '0;
      end else if (flush_req) begin
        locked    <= 1'b0;
        burst_cnt <= '0;
      end else if (locked) begin
        // A locked requester going idle ends its burst early.
        if (!req_valid[lock_id] || (push && burst_cnt == 8'(max_burst - 1))) begin
          locked    <= 1'b0;
          burst_cnt <= '0;
          rr_ptr    <= next_idx(lock_id);
        end else if (push) begin
          burst_cnt <= burst_cnt + 8'd1;
        end
      end else if (push) begin
        if (max_burst > 1) begin
          locked    <= 1'b1;
          lock_id   <= sel;
          burst_cnt <= 8'd1;
        end else begin
          rr_ptr <= next_idx(sel);
        end
      end
    end
  end

endmodule

// File: tb/tb_nvme_fifo_arb.sv
// Directed bench: a max_burst=1 instance and a max_burst=4 instance share
// stimulus; each scenario checks the relevant instance cycle by cycle.
module tb_nvme_fifo_arb;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic            fifo_full, fifo_almost_full, flush_req;

  logic [N-1:0]    a_ready, b_ready;
  logic            a_push, b_push, a_flush, b_flush, a_done, b_done;
  logic [W-1:0]    a_din, b_din;
  logic [IW-1:0]   a_gid, b_gid;

  int checks   = 0;
  int failures = 0;

  nvme_fifo_arb #(.width(W), .nreq(N), .max_burst(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(a_ready), .fifo_push(a_push), .fifo_din(a_din),
    .fifo_flush(a_flush), .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full), .flush_req(flush_req),
    .flush_done(a_done), .grant_id(a_gid));

  nvme_fifo_arb #(.width(W), .nreq(N), .max_burst(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b_ready), .fifo_push(b_push), .fifo_din(b_din),
    .fifo_flush(b_flush), .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full), .flush_req(flush_req),
    .flush_done(b_done), .grant_id(b_gid));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // exp < 0 means no grant this cycle.
  task automatic chk_grant(input string tag, input logic [N-1:0] rdy, input logic psh,
                           input logic [W-1:0] din, input int exp);
    logic [N-1:0] er;
    logic [W-1:0] ed;
    er = (exp < 0) ? '0 : N'(1 << exp);
    ed = (exp < 0) ? '0 : W'(8'hA0 + exp);
    check({tag, "_ready"}, 32'(rdy), 32'(er));
    check({tag, "_push"},  32'(psh), (exp < 0) ? 32'd0 : 32'd1);
    check({tag, "_din"},   32'(din), 32'(ed));
  endtask

  task automatic drive(input logic [N-1:0] v, input logic af, input logic f, input logic fr);
    req_valid = v; fifo_almost_full = af; fifo_full = f; flush_req = fr;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0; flush_req = 1'b0;
    adv();
    reset = 1'b0;
  endtask

  int eb[9]  = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
  int c_af[7] = '{0, 1, 1, 1, 1, 1, 0};
  int c_fu[7] = '{0, 0, 1, 0, 0, 0, 0};
  int c_ex[7] = '{0, 0, -1, 0, 0, -1, 1};
  int g_fl[6] = '{0, 0, 1, 0, 0, 1};
  int g_dn[6] = '{0, 0, 0, 1, 0, 0};

  initial begin
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'hA0 + i);
    reset = 1'b1; req_valid = 4'hF; fifo_full = 1'b0; fifo_almost_full = 1'b0; flush_req = 1'b0;
    #2;
    check("rst_ready", 32'(b_ready), 32'd0);
    check("rst_push",  32'(b_push),  32'd0);
    check("rst_flush", 32'(b_flush), 32'd0);
    check("rst_done",  32'(b_done),  32'd0);
    check("rst_gid",   32'(b_gid),   32'd0);
    check("rst_ready1", 32'(a_ready), 32'd0);
    do_reset();

    // Plain round robin with max_burst = 1
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 1'b0, 1'b0, 1'b0);
      chk_grant("rr", a_ready, a_push, a_din, k % 4);
      check("rr_gid", 32'(a_gid), (k == 0) ? 32'd0 : 32'((k - 1) % 4));
      adv();
    end
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    check("rr_gid_end", 32'(a_gid), 32'd3);

    // Bursts of four between requesters 1 and 2
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(4'b0110, 1'b0, 1'b0, 1'b0);
      chk_grant("burst", b_ready, b_push, b_din, eb[k]);
      adv();
    end

    // almost_full does not stop a running burst; full does
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(4'b0011, c_af[k][0], c_fu[k][0], 1'b0);
      chk_grant("afull", b_ready, b_push, b_din, c_ex[k]);
      adv();
    end

    // Flush after a burst from 2: rr_ptr cleared, requester 0 next
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4'b1100, 1'b0, 1'b0, 1'b0);
      chk_grant("fl_pre", b_ready, b_push, b_din, 2);
      adv();
    end
    drive(4'b1101, 1'b0, 1'b0, 1'b1);
    chk_grant("fl_c0", b_ready, b_push, b_din, -1);
    adv();
    drive(4'b1101, 1'b0, 1'b0, 1'b0);
    chk_grant("fl_c1", b_ready, b_push, b_din, -1);
    check("fl_c1_flush", 32'(b_flush), 32'd0);
    adv();
    drive(4'b1101, 1'b0, 1'b0, 1'b0);
    chk_grant("fl_c2", b_ready, b_push, b_din, -1);
    check("fl_c2_flush", 32'(b_flush), 32'd1);
    adv();
    drive(4'b1101, 1'b0, 1'b0, 1'b0);
    chk_grant("fl_c3", b_ready, b_push, b_din, -1);
    check("fl_c3_done",  32'(b_done),  32'd1);
    check("fl_c3_flush", 32'(b_flush), 32'd0);
    adv();
    drive(4'b1101, 1'b0, 1'b0, 1'b0);
    chk_grant("fl_c4", b_ready, b_push, b_din, 0);
    check("fl_c4_done", 32'(b_done), 32'd0);
    adv();

    // Reset in FLUSH state
    do_reset();
    drive(4'b0000, 1'b0, 1'b0, 1'b1);
    adv();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    adv();
    drive(4'b1010, 1'b0, 1'b0, 1'b0);
    check("rf_flush_on", 32'(b_flush), 32'd1);
    reset = 1'b1;
    #1;
    check("rf_flush_async", 32'(b_flush), 32'd0);
    adv();
    check("rf_done_rst",  32'(b_done),  32'd0);
    check("rf_ready_rst", 32'(b_ready), 32'd0);
    reset = 1'b0;
    drive(4'b1010, 1'b0, 1'b0, 1'b0);
    chk_grant("rf_first", b_ready, b_push, b_din, 1);
    check("rf_done_after", 32'(b_done), 32'd0);
    adv();

    // Locked requester 3 goes idle after two pushes
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(4'b1000, 1'b0, 1'b0, 1'b0);
      chk_grant("drop_pre", b_ready, b_push, b_din, 3);
      adv();
    end
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    chk_grant("drop_rel", b_ready, b_push, b_din, -1);
    adv();
    drive(4'b1001, 1'b0, 1'b0, 1'b0);
    chk_grant("drop_next", b_ready, b_push, b_din, 0);
    adv();

    // flush_req held: DONE goes straight back to DRAIN
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'b0000, 1'b0, 1'b0, 1'b1);
      check("hold_flush", 32'(b_flush), 32'(g_fl[k]));
      check("hold_done",  32'(b_done),  32'(g_dn[k]));
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
